// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU memory arbiter: FSM states, RISC-V
// load/store size codes, memory mask encodings and the load extension helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] MASK_B0  = 4'd0;
  localparam logic [3:0] MASK_B1  = 4'd1;
  localparam logic [3:0] MASK_B2  = 4'd2;
  localparam logic [3:0] MASK_B3  = 4'd3;
  localparam logic [3:0] MASK_H0  = 4'd4;
  localparam logic [3:0] MASK_H1  = 4'd5;
  localparam logic [3:0] MASK_W   = 4'd6;
  localparam logic [3:0] MASK_BU0 = 4'd7;
  localparam logic [3:0] MASK_BU1 = 4'd8;
  localparam logic [3:0] MASK_BU2 = 4'd9;
  localparam logic [3:0] MASK_BU3 = 4'd10;
  localparam logic [3:0] MASK_HU0 = 4'd11;
  localparam logic [3:0] MASK_HU1 = 4'd12;

  // Pick the addressed byte/half out of the memory word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    byte_v = word[{off, 3'b000} +: 8];
    half_v = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   res_v = {{24{byte_v[7]}}, byte_v};
      F3_LH:   res_v = {{16{half_v[15]}}, half_v};
      F3_LW:   res_v = word;
      F3_LBU:  res_v = {24'h000000, byte_v};
      F3_LHU:  res_v = {16'h0000, half_v};
      default: res_v = 32'h0000_0000;
    endcase
    return res_v;
  endfunction

endpackage

// File: rtl/lsu_mask_enc.sv
// Combinational size decoder: maps funct3/we/offset to the memory mask code,
// an illegal-access flag and the lane-placed store data.
module lsu_mask_enc
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        we_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  mask_o,
  output logic        illegal_o,
  output logic [31:0] wdata_o
);

  logic [3:0]  mask_s;
  logic        illegal_s;
  logic [31:0] lane_s;

  // Decode size field; unsigned variants are load-only.
  always_comb begin
    mask_s    = MASK_B0;
    illegal_s = 1'b0;
    lane_s    = 32'h0000_0000;
    case (funct3_i)
      F3_LB: begin
        case (off_i)
          2'd0:    mask_s = MASK_B0;
          2'd1:    mask_s = MASK_B1;
          2'd2:    mask_s = MASK_B2;
          default: mask_s = MASK_B3;
        endcase
        lane_s = {24'h000000, wdata_i[7:0]} << {off_i, 3'b000};
      end
      F3_LH: begin
        mask_s    = off_i[1] ? MASK_H1 : MASK_H0;
        illegal_s = off_i[0];
        lane_s    = off_i[1] ? {wdata_i[15:0], 16'h0000} : {16'h0000, wdata_i[15:0]};
      end
      F3_LW: begin
        mask_s    = MASK_W;
        illegal_s = (off_i != 2'd0);
        lane_s    = wdata_i;
      end
      F3_LBU: begin
        case (off_i)
          2'd0:    mask_s = MASK_BU0;
          2'd1:    mask_s = MASK_BU1;
          2'd2:    mask_s = MASK_BU2;
          default: mask_s = MASK_BU3;
        endcase
        illegal_s = we_i;
      end
      F3_LHU: begin
        mask_s    = off_i[1] ? MASK_HU1 : MASK_HU0;
        illegal_s = we_i | off_i[0];
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  assign mask_o    = illegal_s ? 4'd0 : mask_s;
  assign illegal_o = illegal_s;
  assign wdata_o   = (we_i && !illegal_s) ? lane_s : 32'h0000_0000;

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Two-port LSU arbiter in front of a single-cycle memory. Each request runs
// IDLE -> ACCESS -> RESP; the memory strobes are registered so reset drops them at once.
module lsu_mem_arbiter
  import lsu_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p0_we,
  input  logic [2:0]  p0_funct3,
  output logic        p0_rsp_valid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic        p1_we,
  input  logic [2:0]  p1_funct3,
  output logic        p1_rsp_valid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic        mem_cs,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic        last_grant_q, port_q, we_q, illegal_q;
  logic [2:0]  funct3_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_mask_q;
  logic        mem_rd_en_q, mem_wr_en_q, mem_cs_q;
  logic        p0_rsp_valid_q, p1_rsp_valid_q, p0_err_q, p1_err_q;
  logic [31:0] p0_rdata_q, p1_rdata_q;

  logic        grant_s, any_valid_s, handshake_s;
  logic [31:0] req_addr_s, req_wdata_s, rsp_data_s;
  logic        req_we_s;
  logic [2:0]  req_funct3_s;
  logic [3:0]  enc_mask_s;
  logic        enc_illegal_s;
  logic [31:0] enc_wdata_s;

  assign any_valid_s = p0_valid | p1_valid;

  // Grant selection; round-robin alternates only when both ports contend.
  always_comb begin
    grant_s = 1'b0;
    if (FIXED_PRIO != 0) begin
      grant_s = ~p0_valid;
    end else if (p0_valid && p1_valid) begin
      grant_s = ~last_grant_q;
    end else begin
      grant_s = ~p0_valid;
    end
  end

  assign req_addr_s   = grant_s ? p1_addr   : p0_addr;
  assign req_wdata_s  = grant_s ? p1_wdata  : p0_wdata;
  assign req_we_s     = grant_s ? p1_we     : p0_we;
  assign req_funct3_s = grant_s ? p1_funct3 : p0_funct3;

  lsu_mask_enc u_mask_enc (
    .funct3_i  (req_funct3_s),
    .we_i      (req_we_s),
    .off_i     (req_addr_s[1:0]),
    .wdata_i   (req_wdata_s),
    .mask_o    (enc_mask_s),
    .illegal_o (enc_illegal_s),
    .wdata_o   (enc_wdata_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = any_valid_s ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: combinational ready for the granted port, idle only.
  always_comb begin
    handshake_s = 1'b0;
    p0_ready    = 1'b0;
    p1_ready    = 1'b0;
    if (reset && (state_q == ST_IDLE) && any_valid_s) begin
      handshake_s = 1'b1;
      p0_ready    = ~grant_s;
      p1_ready    = grant_s;
    end else begin
      handshake_s = 1'b0;
    end
  end

  // Request latch and memory-side strobes, live only during ACCESS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      illegal_q    <= 1'b0;
      funct3_q     <= 3'b000;
      mem_addr_q   <= 32'h0000_0000;
      mem_wdata_q  <= 32'h0000_0000;
      mem_mask_q   <= 4'd0;
      mem_cs_q     <= 1'b1;
      mem_wr_en_q  <= 1'b1;
      mem_rd_en_q  <= 1'b0;
    end else if (handshake_s) begin
      last_grant_q <= grant_s;
      port_q       <= grant_s;
      we_q         <= req_we_s;
      illegal_q    <= enc_illegal_s;
      funct3_q     <= req_funct3_s;
      mem_addr_q   <= req_addr_s;
      mem_wdata_q  <= enc_wdata_s;
      mem_mask_q   <= enc_mask_s;
      mem_cs_q     <= enc_illegal_s;
      mem_wr_en_q  <= ~(req_we_s & ~enc_illegal_s);
      mem_rd_en_q  <= ~req_we_s & ~enc_illegal_s;
    end else begin
      mem_cs_q     <= 1'b1;
      mem_wr_en_q  <= 1'b1;
      mem_rd_en_q  <= 1'b0;
    end
  end

  always_comb begin
    rsp_data_s = 32'h0000_0000;
    if (illegal_q || we_q) begin
      rsp_data_s = 32'h0000_0000;
    end else begin
      rsp_data_s = load_extend(funct3_q, mem_addr_q[1:0], mem_rdata);
    end
  end

  // Response registers: loaded at the end of ACCESS, cleared after RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p0_rsp_valid_q <= 1'b0;
      p1_rsp_valid_q <= 1'b0;
      p0_rdata_q     <= 32'h0000_0000;
      p1_rdata_q     <= 32'h0000_0000;
      p0_err_q       <= 1'b0;
      p1_err_q       <= 1'b0;
    end else if (state_q == ST_ACCESS) begin
      p0_rsp_valid_q <= ~port_q;
      p1_rsp_valid_q <= port_q;
      p0_rdata_q     <= port_q ? 32'h0000_0000 : rsp_data_s;
      p1_rdata_q     <= port_q ? rsp_data_s : 32'h0000_0000;
      p0_err_q       <= ~port_q & illegal_q;
      p1_err_q       <= port_q & illegal_q;
    end else begin
      p0_rsp_valid_q <= 1'b0;
      p1_rsp_valid_q <= 1'b0;
      p0_rdata_q     <= 32'h0000_0000;
      p1_rdata_q     <= 32'h0000_0000;
      p0_err_q       <= 1'b0;
      p1_err_q       <= 1'b0;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_mask     = mem_mask_q;
  assign mem_cs       = mem_cs_q;
  assign mem_wr_en    = mem_wr_en_q;
  assign mem_rd_en    = mem_rd_en_q;
  assign p0_rsp_valid = p0_rsp_valid_q;
  assign p1_rsp_valid = p1_rsp_valid_q;
  assign p0_rdata     = p0_rdata_q;
  assign p1_rdata     = p1_rdata_q;
  assign p0_err       = p0_err_q;
  assign p1_err       = p1_err_q;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Self-checking bench for lsu_mem_arbiter: round-robin and fixed-priority
// instances share stimulus; expected values come from an arithmetic access model.
module tb_lsu_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_valid, p1_valid, p0_we, p1_we;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic [2:0]  p0_funct3, p1_funct3;
  logic [31:0] mem_word;

  logic        p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_rd_en, mem_wr_en, mem_cs;

  logic        fp_p0_ready, fp_p1_ready, fp_p0_rsp_valid, fp_p1_rsp_valid, fp_p0_err, fp_p1_err;
  logic [31:0] fp_p0_rdata, fp_p1_rdata, fp_mem_addr, fp_mem_wdata;
  logic [3:0]  fp_mem_mask;
  logic        fp_mem_rd_en, fp_mem_wr_en, fp_mem_cs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_mem_arbiter #(.FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_we(p0_we), .p0_funct3(p0_funct3), .p0_rsp_valid(p0_rsp_valid), .p0_rdata(p0_rdata),
    .p0_err(p0_err),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_we(p1_we), .p1_funct3(p1_funct3), .p1_rsp_valid(p1_rsp_valid), .p1_rdata(p1_rdata),
    .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_cs(mem_cs), .mem_rdata(mem_word)
  );

  lsu_mem_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_ready(fp_p0_ready), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_we(p0_we), .p0_funct3(p0_funct3), .p0_rsp_valid(fp_p0_rsp_valid), .p0_rdata(fp_p0_rdata),
    .p0_err(fp_p0_err),
    .p1_valid(p1_valid), .p1_ready(fp_p1_ready), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_we(p1_we), .p1_funct3(p1_funct3), .p1_rsp_valid(fp_p1_rsp_valid), .p1_rdata(fp_p1_rdata),
    .p1_err(fp_p1_err),
    .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_mask(fp_mem_mask),
    .mem_rd_en(fp_mem_rd_en), .mem_wr_en(fp_mem_wr_en), .mem_cs(fp_mem_cs), .mem_rdata(mem_word)
  );

  // ---------------- reference model (plain arithmetic on the access rules) ----------------
  function automatic bit m_illegal(input logic [2:0] f3, input logic we, input logic [31:0] addr);
    int off;
    int code;
    off  = int'(addr % 32'd4);
    code = int'(f3);
    if (code == 3 || code == 6 || code == 7) return 1'b1;
    if (we && (code == 4 || code == 5)) return 1'b1;
    if ((code == 1 || code == 5) && (off % 2 == 1)) return 1'b1;
    if (code == 2 && off != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] addr);
    int off;
    int m;
    off = int'(addr % 32'd4);
    case (int'(f3))
      0:       m = off;
      1:       m = 4 + off / 2;
      2:       m = 6;
      4:       m = 7 + off;
      5:       m = 11 + off / 2;
      default: m = 0;
    endcase
    return 4'(m);
  endfunction

  function automatic logic [31:0] m_lane(input logic [2:0] f3, input logic [31:0] wdata,
                                         input logic [31:0] addr);
    int off;
    off = int'(addr % 32'd4);
    if (f3 == 3'd0) return (wdata % 32'd256) << (8 * off);
    if (f3 == 3'd1) return (wdata % 32'd65536) << (16 * (off / 2));
    return wdata;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] word,
                                         input logic [31:0] addr);
    int off;
    logic [31:0] b, h;
    off = int'(addr % 32'd4);
    b = (word >> (8 * off)) % 32'd256;
    h = (word >> (16 * (off / 2))) % 32'd65536;
    case (int'(f3))
      0:       return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      1:       return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      2:       return word;
      4:       return b;
      5:       return h;
      default: return 32'h0;
    endcase
  endfunction

  // One single-port transaction on an idle arbiter, checked cycle by cycle.
  task automatic txn(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic we, input logic [2:0] f3, input logic [31:0] word);
    logic        ill, rdy, ordy, rv, orv, er;
    logic [31:0] exp_rd, rd;
    ill    = m_illegal(f3, we, addr);
    exp_rd = (ill || we) ? 32'h0 : m_load(f3, word, addr);
    @(posedge clk); #1;
    mem_word = word;
    if (port == 0) begin
      p0_valid = 1'b1; p0_addr = addr; p0_wdata = wdata; p0_we = we; p0_funct3 = f3;
    end else begin
      p1_valid = 1'b1; p1_addr = addr; p1_wdata = wdata; p1_we = we; p1_funct3 = f3;
    end
    @(negedge clk);
    rdy  = (port == 0) ? p0_ready : p1_ready;
    ordy = (port == 0) ? p1_ready : p0_ready;
    n_checks += 2;
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL txn_ready p%0d: got %b want 1", port, rdy); end
    if (ordy !== 1'b0) begin n_fail++; $display("FAIL txn_other_ready p%0d: got %b want 0", port, ordy); end
    @(posedge clk); #1;
    p0_valid = 1'b0; p1_valid = 1'b0;
    @(negedge clk);
    n_checks += 4;
    if (mem_cs !== ill) begin n_fail++; $display("FAIL access_cs a=%h f3=%0d we=%b: got %b want %b", addr, f3, we, mem_cs, ill); end
    if (mem_rd_en !== (!ill && !we)) begin n_fail++; $display("FAIL access_rd_en: got %b want %b", mem_rd_en, (!ill && !we)); end
    if (mem_wr_en !== !(!ill && we)) begin n_fail++; $display("FAIL access_wr_en: got %b want %b", mem_wr_en, !(!ill && we)); end
    if (mem_addr !== addr) begin n_fail++; $display("FAIL access_addr: got %h want %h", mem_addr, addr); end
    if (!ill) begin
      n_checks++;
      if (mem_mask !== m_mask(f3, addr)) begin n_fail++; $display("FAIL access_mask a=%h f3=%0d: got %0d want %0d", addr, f3, mem_mask, m_mask(f3, addr)); end
    end
    if (!ill && we) begin
      n_checks++;
      if (mem_wdata !== m_lane(f3, wdata, addr)) begin n_fail++; $display("FAIL access_wdata: got %h want %h", mem_wdata, m_lane(f3, wdata, addr)); end
    end
    @(negedge clk);
    rv  = (port == 0) ? p0_rsp_valid : p1_rsp_valid;
    orv = (port == 0) ? p1_rsp_valid : p0_rsp_valid;
    rd  = (port == 0) ? p0_rdata : p1_rdata;
    er  = (port == 0) ? p0_err : p1_err;
    n_checks += 6;
    if (rv !== 1'b1) begin n_fail++; $display("FAIL resp_valid p%0d: got %b want 1", port, rv); end
    if (orv !== 1'b0) begin n_fail++; $display("FAIL resp_other_valid: got %b want 0", orv); end
    if (rd !== exp_rd) begin n_fail++; $display("FAIL resp_rdata a=%h f3=%0d we=%b: got %h want %h", addr, f3, we, rd, exp_rd); end
    if (er !== ill) begin n_fail++; $display("FAIL resp_err: got %b want %b", er, ill); end
    if (mem_cs !== 1'b1) begin n_fail++; $display("FAIL resp_cs: got %b want 1", mem_cs); end
    if (mem_wr_en !== 1'b1) begin n_fail++; $display("FAIL resp_wr_en: got %b want 1", mem_wr_en); end
    @(negedge clk);
    n_checks++;
    if (rv !== 1'b1 || (p0_rsp_valid | p1_rsp_valid) !== 1'b0) begin
      n_fail++; $display("FAIL resp_one_cycle: got %b want 0", p0_rsp_valid | p1_rsp_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    p0_valid = 1'b1; p1_valid = 1'b1;
    repeat (2) @(negedge clk);
    n_checks += 12;
    if ({p0_ready, p1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {p0_ready, p1_ready}); end
    if ({fp_p0_ready, fp_p1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_fp_ready: got %b want 00", {fp_p0_ready, fp_p1_ready}); end
    if (mem_cs !== 1'b1) begin n_fail++; $display("FAIL reset_cs: got %b want 1", mem_cs); end
    if (mem_wr_en !== 1'b1) begin n_fail++; $display("FAIL reset_wr_en: got %b want 1", mem_wr_en); end
    if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", mem_rd_en); end
    if (mem_mask !== 4'd0) begin n_fail++; $display("FAIL reset_mask: got %0d want 0", mem_mask); end
    if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
    if ({p0_rsp_valid, p1_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", {p0_rsp_valid, p1_rsp_valid}); end
    if (p0_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_p0_rdata: got %h want 0", p0_rdata); end
    if (p1_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_p1_rdata: got %h want 0", p1_rdata); end
    if ({p0_err, p1_err} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", {p0_err, p1_err}); end
    p0_valid = 1'b0; p1_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_directed();
    txn(0, 32'h0000_0010, 32'h0, 1'b0, 3'b010, 32'hDEAD_BEEF);
    txn(1, 32'h0000_0013, 32'h0, 1'b0, 3'b000, 32'h80FF_FFFF);
    txn(1, 32'h0000_0013, 32'h0, 1'b0, 3'b100, 32'h80FF_FFFF);
    txn(0, 32'h0000_0022, 32'h0000_1234, 1'b1, 3'b001, 32'h0);
    txn(0, 32'h0000_0002, 32'h0, 1'b0, 3'b010, 32'h1234_5678);
    txn(1, 32'h0000_0031, 32'hAABB_CCDD, 1'b1, 3'b000, 32'h0);
    txn(0, 32'h0000_0040, 32'hCAFE_F00D, 1'b1, 3'b010, 32'h0);
    txn(1, 32'h0000_0044, 32'h0, 1'b1, 3'b100, 32'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      txn(int'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)), $urandom);
    end
  endtask

  // Requests arriving in ACCESS/RESP must wait; withdrawing them before IDLE starts nothing.
  task automatic test_drop();
    @(posedge clk); #1;
    p0_valid = 1'b1; p0_addr = 32'h40; p0_we = 1'b0; p0_funct3 = 3'b010;
    @(negedge clk);
    n_checks++;
    if (p0_ready !== 1'b1) begin n_fail++; $display("FAIL drop_p0_ready: got %b want 1", p0_ready); end
    @(posedge clk); #1;
    p0_valid = 1'b0;
    p1_valid = 1'b1; p1_addr = 32'h80; p1_we = 1'b0; p1_funct3 = 3'b010;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (p1_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready cycle %0d: got %b want 0", c, p1_ready); end
    end
    @(posedge clk); #1;
    p1_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({p0_ready, p1_ready} !== 2'b00) begin n_fail++; $display("FAIL drop_idle_ready: got %b want 00", {p0_ready, p1_ready}); end
    @(negedge clk);
    n_checks += 2;
    if (mem_cs !== 1'b1) begin n_fail++; $display("FAIL drop_no_access: got %b want 1", mem_cs); end
    if (p1_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL drop_no_rsp: got %b want 0", p1_rsp_valid); end
  endtask

  task automatic test_arbitration();
    int last;
    int g;
    bit e0, e1;
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    last = 1;
    p0_valid = 1'b1; p0_addr = 32'h0; p0_we = 1'b0; p0_funct3 = 3'b010;
    p1_valid = 1'b1; p1_addr = 32'h4; p1_we = 1'b0; p1_funct3 = 3'b010;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      e0 = 1'b0; e1 = 1'b0;
      if (c % 3 == 0) begin
        g = 1 - last;
        last = g;
        e0 = (g == 0);
        e1 = (g == 1);
      end
      n_checks += 4;
      if (p0_ready !== e0) begin n_fail++; $display("FAIL rr_p0_ready cycle %0d: got %b want %b", c, p0_ready, e0); end
      if (p1_ready !== e1) begin n_fail++; $display("FAIL rr_p1_ready cycle %0d: got %b want %b", c, p1_ready, e1); end
      if (fp_p0_ready !== (c % 3 == 0)) begin n_fail++; $display("FAIL fp_p0_ready cycle %0d: got %b want %b", c, fp_p0_ready, (c % 3 == 0)); end
      if (fp_p1_ready !== 1'b0) begin n_fail++; $display("FAIL fp_p1_ready cycle %0d: got %b want 0", c, fp_p1_ready); end
    end
    @(posedge clk); #1;
    p0_valid = 1'b0; p1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    @(posedge clk); #1;
    p1_valid = 1'b1; p1_addr = 32'h8; p1_we = 1'b0; p1_funct3 = 3'b010;
    @(negedge clk);
    n_checks++;
    if (p1_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", p1_ready); end
    @(posedge clk); #1;
    p1_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_cs !== 1'b0) begin n_fail++; $display("FAIL rst_mid_access_cs: got %b want 0", mem_cs); end
    #2 reset = 1'b0;
    #1;
    n_checks += 2;
    if (mem_cs !== 1'b1) begin n_fail++; $display("FAIL rst_mid_cs_immediate: got %b want 1", mem_cs); end
    if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rd_en: got %b want 0", mem_rd_en); end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({p0_rsp_valid, p1_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_no_rsp cycle %0d: got %b want 00", c, {p0_rsp_valid, p1_rsp_valid}); end
    end
    @(posedge clk); #1;
    p0_valid = 1'b1; p1_valid = 1'b1;
    @(negedge clk);
    n_checks += 2;
    if (p0_ready !== 1'b1) begin n_fail++; $display("FAIL rst_first_grant_p0: got %b want 1", p0_ready); end
    if (p1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_first_grant_p1: got %b want 0", p1_ready); end
    @(posedge clk); #1;
    p0_valid = 1'b0; p1_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    p0_valid = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0; p0_we = 1'b0; p0_funct3 = 3'b000;
    p1_valid = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0; p1_we = 1'b0; p1_funct3 = 3'b000;
    mem_word = 32'h0;
    test_reset();
    test_directed();
    test_random();
    test_drop();
    test_arbitration();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
